ifetch_prefetch_buf: RTL

Instruction prefetch buffer between the instruction memory bus and the fetch/IF stage. Owns the sequential fetch address, issues one-at-a-time requests to instruction memory with a variable-latency valid/grant handshake, and queues returned instructions with their addresses in a DEPTH-entry FIFO. It presents them to the IF stage through a valid/ready interface. A taken jump flushes the queue and any in-flight response, then restarts fetching at the jump target.

---
 rtl/ifetch_prefetch_buf_if.sv | 28 ++
 rtl/ifetch_prefetch_buf.sv | 78 +++++++
 2 files changed

// File: rtl/ifetch_prefetch_buf_if.sv
// ifetch_prefetch_buf_if: memory-bus, IF-stage and redirect signals of the prefetch buffer
// master = the prefetch buffer, slave = its environment (memory, IF stage, jump source).
interface ifetch_prefetch_buf_if #(
    parameter int DEPTH = 4
);
    logic                   jump_flag_i;
    logic [31:0]            jump_addr_i;
    logic                   mem_req_o;
    logic [31:0]            mem_addr_o;
    logic                   mem_gnt_i;
    logic                   mem_rvalid_i;
    logic [31:0]            mem_rdata_i;
    logic                   ins_valid_o;
    logic                   ins_ready_i;
    logic [31:0]            ins_o;
    logic [31:0]            ins_addr_o;
    logic [$clog2(DEPTH):0] count_o;

    modport master (
        input  jump_flag_i, jump_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, ins_ready_i,
        output mem_req_o, mem_addr_o, ins_valid_o, ins_o, ins_addr_o, count_o
    );

    modport slave (
        output jump_flag_i, jump_addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i, ins_ready_i,
        input  mem_req_o, mem_addr_o, ins_valid_o, ins_o, ins_addr_o, count_o
    );
endinterface

// File: rtl/ifetch_prefetch_buf.sv
// ifetch_prefetch_buf: sequential instruction prefetcher with a DEPTH-entry {addr, data} queue.
// Define PREFETCH_BYPASS_EN to forward a response straight to IF when the queue is empty.
module ifetch_prefetch_buf #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                   clk,
    input logic                   rst,
    ifetch_prefetch_buf_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_REQ = 2'd0, S_WAIT = 2'd1, S_DISCARD = 2'd2;

    logic [1:0]    state, state_n;
    logic [31:0]   fetch_pc;
    logic [31:0]   buf_addr [DEPTH];
    logic [31:0]   buf_data [DEPTH];
    logic [AW-1:0] rptr, wptr;
    logic [AW:0]   count;
    logic          jump, empty, req, fire, resp, bypass, push, pop, drop;

    always_comb begin
        jump  = bus.jump_flag_i;
        empty = count == '0;
        req   = !rst && state == S_REQ && count < (AW+1)'(DEPTH);
        fire  = req && bus.mem_gnt_i;
        resp  = state == S_WAIT && bus.mem_rvalid_i;
`ifdef PREFETCH_BYPASS_EN
        bypass = empty && resp && !jump;
`else
        bypass = 1'b0;
`endif
        push  = resp && !jump && !(bypass && bus.ins_ready_i);
        pop   = !empty && bus.ins_ready_i && !jump;
        // a jump leaves a response still owed by memory whenever one is outstanding after this edge
        drop  = (state != S_REQ && !bus.mem_rvalid_i) || fire;
        state_n = jump ? (drop ? S_DISCARD : S_REQ) :
                  fire ? S_WAIT :
                  (state != S_REQ && bus.mem_rvalid_i) ? S_REQ : state;
    end

    assign bus.mem_req_o   = req;
    assign bus.mem_addr_o  = fetch_pc;
    assign bus.ins_valid_o = !empty || bypass;
    assign bus.ins_o       = !empty ? buf_data[rptr] : bypass ? bus.mem_rdata_i : '0;
    assign bus.ins_addr_o  = !empty ? buf_addr[rptr] : bypass ? fetch_pc : '0;
    assign bus.count_o     = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
        end else begin
            state <= state_n;
            if (jump) begin
                fetch_pc <= bus.jump_addr_i & ~32'h3;
                rptr     <= '0;
                wptr     <= '0;
                count    <= '0;
            end else begin
                if (resp) fetch_pc <= fetch_pc + 32'd4;
                wptr  <= wptr + AW'(push);
                rptr  <= rptr + AW'(pop);
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wptr] <= fetch_pc;
            buf_data[wptr] <= bus.mem_rdata_i;
        end
    end
endmodule
